clock_mode_ctrl: RTL

Control block for the digital clock's time datapath. Owns the running seconds-of-day register and the alarm register, and advances time on a 1 Hz enable. A button-driven state machine sequences time and alarm setting, and compares time against the alarm to drive the ring output. Its `count`, `count_alarm`, `mode` and `alarm_en` outputs feed the time-to-BCD split stage directly.

---
 rtl/clock_mode_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: time/alarm control for the digital clock.
// Holds seconds-of-day and the alarm time, sequences setting through a
// key-driven FSM and drives the ring output on an alarm match.
// Optional feature macro: CLOCK_SNOOZE_EN (key_stop during ring snoozes).
module clock_mode_ctrl #(
  parameter int unsigned DAY_SECONDS  = 86400,
  parameter int unsigned RING_SECONDS = 60
`ifdef CLOCK_SNOOZE_EN
  ,
  parameter int unsigned SNOOZE_SECONDS = 300
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        key_dec,
  input  logic        key_fmt,
  input  logic        key_arm,
  input  logic        key_stop,
  output logic [20:0] count,
  output logic [20:0] count_alarm,
  output logic        mode,
  output logic        alarm_en,
  output logic        alarm_armed,
  output logic        ring,
  output logic [2:0]  state
);

  localparam logic [20:0] DAY_L       = 21'(DAY_SECONDS);
  localparam logic [20:0] HOUR_L      = 21'd3600;
  localparam logic [20:0] MIN_L       = 21'd60;
  localparam logic [20:0] LAST_HOUR_L = DAY_L - HOUR_L;
  localparam logic [20:0] RING_L      = 21'(RING_SECONDS);
`ifdef CLOCK_SNOOZE_EN
  localparam logic [20:0] SNOOZE_L    = 21'(SNOOZE_SECONDS);
`endif

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_SET_HOUR = 3'd1,
    S_SET_MIN  = 3'd2,
    S_ALM_HOUR = 3'd3,
    S_ALM_MIN  = 3'd4
  } state_t;

  // Advance one second, wrapping at midnight.
  function automatic logic [20:0] tick_next(input logic [20:0] v);
    return (v == DAY_L - 21'd1) ? 21'd0 : v + 21'd1;
  endfunction

  // Drop the seconds field.
  function automatic logic [20:0] clr_sec(input logic [20:0] v);
    return v - (v % MIN_L);
  endfunction

  // Hour/minute edit; each field wraps on its own without carrying.
  function automatic logic [20:0] edit_field(input logic [20:0] v,
                                             input logic hour_fld,
                                             input logic up);
    logic [20:0] r;
    if (hour_fld) begin
      if (up) r = (v >= LAST_HOUR_L) ? v - LAST_HOUR_L : v + HOUR_L;
      else    r = (v < HOUR_L) ? v + LAST_HOUR_L : v - HOUR_L;
    end else begin
      if (up) r = ((v % HOUR_L) >= 21'd3540) ? v - 21'd3540 : v + MIN_L;
      else    r = ((v % HOUR_L) < MIN_L) ? v + 21'd3540 : v - MIN_L;
    end
    return r;
  endfunction

  state_t      state_q;
  logic [20:0] count_q, count_d;
  logic [20:0] alarm_q, alarm_d;
  logic [20:0] rcnt_q, rcnt_d;
  logic        mode_q, alarm_en_q, armed_q;
  logic        ring_q, ring_d;
  logic        frozen, in_alarm, edit_ok, trigger;
  logic [20:0] ticked;
`ifdef CLOCK_SNOOZE_EN
  logic [20:0] snz_q, snz_d;
`endif

  // Next-state values for time, alarm and the ring/snooze counters.
  always_comb begin
    frozen   = (state_q == S_SET_HOUR) || (state_q == S_SET_MIN);
    in_alarm = (state_q == S_ALM_HOUR) || (state_q == S_ALM_MIN);
    edit_ok  = !key_mode && (key_inc ^ key_dec);
    ticked   = tick_next(count_q);
    trigger  = armed_q && !frozen && tick_1hz && (ticked == alarm_q);

    count_d = count_q;
    if (tick_1hz && !frozen) count_d = ticked;
    if (key_mode && (state_q == S_RUN)) count_d = clr_sec(count_d);
    if (edit_ok && frozen)
      count_d = edit_field(count_q, state_q == S_SET_HOUR, key_inc);

    alarm_d = alarm_q;
    if (edit_ok && in_alarm)
      alarm_d = edit_field(alarm_q, state_q == S_ALM_HOUR, key_inc);

    ring_d = ring_q;
    rcnt_d = rcnt_q;
`ifdef CLOCK_SNOOZE_EN
    snz_d  = snz_q;
`endif
    if (tick_1hz && ring_q && (rcnt_q != 21'd0)) begin
      rcnt_d = rcnt_q - 21'd1;
      if (rcnt_q == 21'd1) ring_d = 1'b0;
    end
`ifdef CLOCK_SNOOZE_EN
    if (tick_1hz && (snz_q != 21'd0)) begin
      snz_d = snz_q - 21'd1;
      if (snz_q == 21'd1) begin
        ring_d = 1'b1;
        rcnt_d = RING_L;
      end
    end
`endif
    if (trigger) begin
      ring_d = 1'b1;
      rcnt_d = RING_L;
`ifdef CLOCK_SNOOZE_EN
      snz_d  = 21'd0;
`endif
    end
    if (key_stop) begin
      ring_d = 1'b0;
      rcnt_d = 21'd0;
`ifdef CLOCK_SNOOZE_EN
      if (ring_q) snz_d = SNOOZE_L;
`endif
    end
    // Disarming silences the buzzer and cancels any pending snooze.
    if (key_arm && armed_q) begin
      ring_d = 1'b0;
      rcnt_d = 21'd0;
`ifdef CLOCK_SNOOZE_EN
      snz_d  = 21'd0;
`endif
    end
  end

  // Mode FSM with registered alarm-display select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      alarm_en_q <= 1'b0;
    end else if (key_mode) begin
      case (state_q)
        S_RUN:      begin state_q <= S_SET_HOUR; alarm_en_q <= 1'b0; end
        S_SET_HOUR: begin state_q <= S_SET_MIN;  alarm_en_q <= 1'b0; end
        S_SET_MIN:  begin state_q <= S_ALM_HOUR; alarm_en_q <= 1'b1; end
        S_ALM_HOUR: begin state_q <= S_ALM_MIN;  alarm_en_q <= 1'b1; end
        default:    begin state_q <= S_RUN;      alarm_en_q <= 1'b0; end
      endcase
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 21'd0;
      alarm_q <= 21'd0;
      rcnt_q  <= 21'd0;
      mode_q  <= 1'b0;
      armed_q <= 1'b0;
      ring_q  <= 1'b0;
`ifdef CLOCK_SNOOZE_EN
      snz_q   <= 21'd0;
`endif
    end else begin
      count_q <= count_d;
      alarm_q <= alarm_d;
      rcnt_q  <= rcnt_d;
      ring_q  <= ring_d;
      mode_q  <= mode_q ^ key_fmt;
      armed_q <= armed_q ^ key_arm;
`ifdef CLOCK_SNOOZE_EN
      snz_q   <= snz_d;
`endif
    end
  end

  assign count       = count_q;
  assign count_alarm = alarm_q;
  assign mode        = mode_q;
  assign alarm_en    = alarm_en_q;
  assign alarm_armed = armed_q;
  assign ring        = ring_q;
  assign state       = state_q;

endmodule
